upload_arbiter: RTL and testbench

Parametrised N-channel arbiter that replaces the fixed OR-merge of handler upload streams in front of `command_processor`. Each handler keeps its own `upload_req` / `upload_data` / `upload_source` / `upload_valid` / `upload_ready` interface. The arbiter grants exactly one channel at a time and holds that grant for the whole packet, as long as that channel holds `upload_req`. It routes that channel's bytes to the processor, steers the processor's ready only to the granted channel, and recovers from stalled channels with a watchdog.

---
 rtl/upload_arbiter.sv | 100 ++++++++++
 tb/tb_upload_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/upload_arbiter.sv
// upload_arbiter: N-channel packet arbiter merging handler upload streams into command_processor
module upload_arbiter #(
  parameter int                NUM_CH  = 4,
  parameter int                MODE    = 0,
  parameter logic [NUM_CH-1:0] CH_MASK = '1,
  parameter int                TIMEOUT = 1024,
  localparam int               IW      = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     up_req,
  input  logic [NUM_CH*8-1:0]   up_data,
  input  logic [NUM_CH*8-1:0]   up_source,
  input  logic [NUM_CH-1:0]     up_valid,
  output logic [NUM_CH-1:0]     up_ready,
  output logic                  m_req,
  output logic [7:0]            m_data,
  output logic [7:0]            m_source,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [NUM_CH-1:0]     grant,
  output logic                  busy,
  output logic                  timeout_pulse,
  output logic [IW-1:0]         timeout_ch
);
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t            state_q;
  logic [IW-1:0]     gnt_idx_q, rr_last_q, timeout_ch_q, win;
  logic [WW-1:0]     wd_cnt_q;
  logic [NUM_CH-1:0] grant_q, elig;
  logic              busy_q, m_req_q, timeout_pulse_q, found, xfer, wd_fire, leave;
  int                c;
  assign elig    = up_req & CH_MASK;
  assign xfer    = up_valid[gnt_idx_q] & m_ready;
  assign wd_fire = TIMEOUT != 0 && up_req[gnt_idx_q] && !xfer && wd_cnt_q == WD_MAX;
  assign leave   = !up_req[gnt_idx_q] || wd_fire;
  // Winner search: rotating scan after the last grant, or lowest index in fixed-priority mode
  always_comb begin
    win   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = MODE == 1 ? k : (int'(rr_last_q) + 1 + k) % NUM_CH;
      if (!found && elig[c]) begin
        win   = IW'(c);
        found = 1'b1;
      end
    end
  end
  // Arbitration FSM with watchdog; all control outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      gnt_idx_q       <= '0;
      rr_last_q       <= IW'(NUM_CH - 1);
      wd_cnt_q        <= '0;
      timeout_ch_q    <= '0;
      timeout_pulse_q <= 1'b0;
      grant_q         <= '0;
      busy_q          <= 1'b0;
      m_req_q         <= 1'b0;
    end else begin
      timeout_pulse_q <= 1'b0;
      if (state_q == IDLE) begin
        if (|elig) begin
          state_q   <= GRANT;
          gnt_idx_q <= win;
          grant_q   <= NUM_CH'(1) << win;
          busy_q    <= 1'b1;
          m_req_q   <= 1'b1;
          wd_cnt_q  <= '0;
        end
      end else if (leave) begin
        state_q   <= IDLE;
        rr_last_q <= gnt_idx_q;
        wd_cnt_q  <= '0;
        grant_q   <= '0;
        busy_q    <= 1'b0;
        m_req_q   <= 1'b0;
        if (wd_fire) begin
          timeout_pulse_q <= 1'b1;
          timeout_ch_q    <= gnt_idx_q;
        end
      end else begin
        wd_cnt_q <= xfer ? '0 : wd_cnt_q + WW'(1);
      end
    end
  end
  assign m_data        = busy_q ? up_data[{gnt_idx_q, 3'b000} +: 8] : 8'h00;
  assign m_source      = busy_q ? up_source[{gnt_idx_q, 3'b000} +: 8] : 8'h00;
  assign m_valid       = busy_q & up_valid[gnt_idx_q];
  assign up_ready      = m_ready ? grant_q : '0;
  assign grant         = grant_q;
  assign busy          = busy_q;
  assign m_req         = m_req_q;
  assign timeout_pulse = timeout_pulse_q;
  assign timeout_ch    = timeout_ch_q;
endmodule

// File: tb/tb_upload_arbiter.sv
// tb_upload_arbiter: directed checks of round-robin, priority, mask, watchdog and reset behaviour
module tb_upload_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0, valid = '0;
  logic [31:0] data = '0, src = '0;
  logic        mrdy = 1'b0;
  logic [3:0]  a_ready, a_grant, b_ready, b_grant;
  logic [7:0]  a_mdata, a_msrc, b_mdata, b_msrc;
  logic        a_mreq, a_mvalid, a_busy, a_tp, b_mreq, b_mvalid, b_busy, b_tp;
  logic [1:0]  a_tch, b_tch;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  upload_arbiter #(.NUM_CH(4), .MODE(0), .CH_MASK(4'b1111), .TIMEOUT(16)) u_a (
    .clk(clk), .rst_n(rst_n), .up_req(req), .up_data(data), .up_source(src), .up_valid(valid),
    .up_ready(a_ready), .m_req(a_mreq), .m_data(a_mdata), .m_source(a_msrc), .m_valid(a_mvalid),
    .m_ready(mrdy), .grant(a_grant), .busy(a_busy), .timeout_pulse(a_tp), .timeout_ch(a_tch)
  );
  upload_arbiter #(.NUM_CH(4), .MODE(1), .CH_MASK(4'b1011), .TIMEOUT(16)) u_b (
    .clk(clk), .rst_n(rst_n), .up_req(req), .up_data(data), .up_source(src), .up_valid(valid),
    .up_ready(b_ready), .m_req(b_mreq), .m_data(b_mdata), .m_source(b_msrc), .m_valid(b_mvalid),
    .m_ready(mrdy), .grant(b_grant), .busy(b_busy), .timeout_pulse(b_tp), .timeout_ch(b_tch)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; valid = '0; data = '0; src = '0; mrdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    int w, n, g;
    do_reset();
    chk("rst_grant", a_grant, 0);
    chk("rst_mreq", a_mreq, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_tp", a_tp, 0);
    chk("rst_tch", a_tch, 0);
    chk("rst_mdata", a_mdata, 0);
    // single packet on ch1, req dropped with the last byte
    req[1] = 1'b1; valid[1] = 1'b1; mrdy = 1'b1; data[15:8] = 8'hA1; src[15:8] = 8'h03;
    #1 chk("t1_pre_grant", a_grant, 0);
    cyc();
    chk("t1_grant", a_grant, 4'b0010);
    chk("t1_mreq", a_mreq, 1);
    for (int i = 0; i < 4; i++) begin
      data[15:8] = 8'hA1 + 8'(i);
      if (i == 3) req[1] = 1'b0;
      #1;
      chk("t1_mdata", a_mdata, 32'hA1 + i);
      chk("t1_msrc", a_msrc, 8'h03);
      chk("t1_mvalid", a_mvalid, 1);
      chk("t1_ready", a_ready, 4'b0010);
      cyc();
    end
    chk("t1_mreq_drop", a_mreq, 0);
    chk("t1_grant_drop", a_grant, 0);
    chk("t1_ready_idle", a_ready, 0);
    chk("t1_mdata_idle", a_mdata, 0);
    // round-robin between ch0 and ch2
    do_reset();
    req = 4'b0101; valid = 4'b0101; mrdy = 1'b1;
    for (int p = 0; p < 4; p++) begin
      g = (p % 2 == 1) ? 2 : 0;
      w = 0;
      while (a_grant == 0 && w < 8) begin
        cyc();
        w++;
      end
      chk("t2_idle_gap", w, 1);
      chk("t2_grant", a_grant, 32'(1) << g);
      for (int b = 0; b < 2; b++) begin
        data[8*g +: 8] = 8'(8'h10 + p * 2 + b);
        if (b == 1) req[g] = 1'b0;
        #1;
        chk("t2_mdata", a_mdata, 32'h10 + p * 2 + b);
        chk("t2_mvalid", a_mvalid, 1);
        cyc();
      end
      req[g] = 1'b1;
    end
    // fixed priority: ch3 packet finishes, then ch0 wins over ch3
    do_reset();
    req[3] = 1'b1; valid[3] = 1'b1; mrdy = 1'b1;
    cyc();
    chk("t3_grant3", b_grant, 4'b1000);
    for (int b = 0; b < 3; b++) begin
      data[31:24] = 8'(8'hC0 + b);
      if (b == 0) begin req[0] = 1'b1; valid[0] = 1'b1; end
      if (b == 2) req[3] = 1'b0;
      #1;
      chk("t3_hold", b_grant, 4'b1000);
      chk("t3_mdata", b_mdata, 32'hC0 + b);
      chk("t3_ready", b_ready, 4'b1000);
      cyc();
    end
    chk("t3_idle", b_grant, 0);
    req[3] = 1'b1;
    cyc();
    chk("t3_grant0", b_grant, 4'b0001);
    chk("t3_mdata0", b_mdata, data[7:0]);
    // masked channel 2 is never served
    do_reset();
    req[2] = 1'b1; valid[2] = 1'b1; mrdy = 1'b1;
    repeat (5) begin
      cyc();
      chk("t4_grant", b_grant, 0);
      chk("t4_mreq", b_mreq, 0);
      chk("t4_ready", b_ready, 0);
    end
    // watchdog on stalled ch1, pending ch2 next
    do_reset();
    req[1] = 1'b1; mrdy = 1'b1;
    cyc();
    chk("t5_grant1", a_grant, 4'b0010);
    req[2] = 1'b1;
    n = 0;
    while (a_busy && n < 40) begin
      chk("t5_no_pulse", a_tp, 0);
      n++;
      cyc();
    end
    chk("t5_cycles", n, 16);
    chk("t5_pulse", a_tp, 1);
    chk("t5_tch", a_tch, 1);
    chk("t5_idle", a_grant, 0);
    cyc();
    chk("t5_pulse_end", a_tp, 0);
    chk("t5_grant2", a_grant, 4'b0100);
    chk("t5_tch_hold", a_tch, 1);
    // asynchronous reset in the middle of a ch0 packet
    do_reset();
    req[0] = 1'b1; valid[0] = 1'b1; mrdy = 1'b1; data[7:0] = 8'h51;
    cyc();
    chk("t6_grant", a_grant, 4'b0001);
    cyc();
    data[7:0] = 8'h52;
    #1 chk("t6_mdata", a_mdata, 8'h52);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", a_grant, 0);
    chk("t6_rst_ready", a_ready, 0);
    chk("t6_rst_mreq", a_mreq, 0);
    chk("t6_rst_mdata", a_mdata, 0);
    chk("t6_rst_mvalid", a_mvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("t6_regrant", a_grant, 4'b0001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
